// File: rtl/multiplier_input_conditioner.sv
// Board-pin front end for the 8-bit multiplier: synchronizes and debounces the
// keys, turns accepted presses into single-cycle pulses and freezes S while Busy.
module multiplier_input_conditioner #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_n,
    input  logic       ClearA_LoadB_n,
    input  logic [7:0] SW,
    input  logic       Busy,
    output logic       Run,
    output logic       ClearA_LoadB,
    output logic [7:0] S,
    output logic       RunLevel,
    output logic       ClrLevel
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bit 0 is the Run key, bit 1 the ClearA_LoadB key.
    logic [1:0]       key_raw;
    logic [1:0]       key_s1;
    logic [1:0]       key_s2;
    logic [1:0]       stable;
    logic [1:0]       flip;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];
    logic [7:0]       sw_s1;
    logic [7:0]       sw_s2;

    assign key_raw = {ClearA_LoadB_n, Run_n};

    always_comb begin
        flip  = '0;
        press = '0;
        for (int k = 0; k < 2; k++) begin
            flip[k]  = (key_s2[k] != stable[k]) && (cnt[k] == CNT_MAX);
            press[k] = flip[k] & stable[k];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            stable <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            for (int k = 0; k < 2; k++) begin
                if (key_s2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (flip[k]) begin
                    stable[k] <= key_s2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Presses landing while Busy are dropped; Clear beats Run on a tie.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Run          <= 1'b0;
            ClearA_LoadB <= 1'b0;
            sw_s1        <= '0;
            sw_s2        <= '0;
            S            <= '0;
        end else begin
            Run          <= press[0] & ~Busy & ~press[1];
            ClearA_LoadB <= press[1] & ~Busy;
            sw_s1        <= SW;
            sw_s2        <= sw_s1;
            if (!Busy) begin
                S <= sw_s2;
            end
        end
    end

    assign RunLevel = ~stable[0];
    assign ClrLevel = ~stable[1];

endmodule
